// File: rtl/ilift_pkg.sv
// Shared definitions for the inverse integer lifting stage: widths, lifting
// shift amounts (common with the forward stage) and the serializer states.
package ilift_pkg;

  localparam int ILIFT_W = 8;
  localparam int PRED_SH = 1;
  localparam int UPD_SH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ilift_core.sv
// Combinational inverse lifting (L, H) -> (even, odd), modulo 2^W.
// Also usable as a golden inverse in forward-stage benches.
module ilift_core
  import ilift_pkg::*;
#(
  parameter int W = ILIFT_W
) (
  input  logic [W-1:0] i_l,
  input  logic [W-1:0] i_h,
  output logic [W-1:0] o_even,
  output logic [W-1:0] o_odd
);

  logic [W-1:0] w_d;
  logic [W-1:0] w_s;

  // Undo update first, then undo predict using the recovered even sample.
  always_comb begin
    w_d    = i_h >> UPD_SH;
    o_even = i_l - w_d - w_d;
    w_s    = o_even >> PRED_SH;
    o_odd  = i_h + w_s + w_s;
  end

endmodule

// File: rtl/ilift_decode.sv
// Inverse lifting stage: one (L, H) pair in, even then odd sample out.
// Optional accepted-pair counter enabled by defining ILIFT_CNT_EN.
module ilift_decode
  import ilift_pkg::*;
#(
  parameter int W = ILIFT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_l,
  input  logic [W-1:0] i_in_h,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_out_even
`ifdef ILIFT_CNT_EN
  ,
  output logic [15:0]  o_pair_cnt
`endif
);

  ser_state_t   r_state;
  ser_state_t   w_state_nxt;
  logic         r_s1_valid;
  logic [W-1:0] r_s1_l;
  logic [W-1:0] r_s1_h;
  logic [W-1:0] r_ob_even;
  logic [W-1:0] r_ob_odd;
  logic [W-1:0] w_even;
  logic [W-1:0] w_odd;
  logic         w_ob_load;
  logic         w_accept;

  // S1 keeps the raw coefficients; the core resolves even/odd as S1 moves into OB.
  ilift_core #(.W(W)) u_core (
    .i_l    (r_s1_l),
    .i_h    (r_s1_h),
    .o_even (w_even),
    .o_odd  (w_odd)
  );

  assign w_ob_load  = r_s1_valid &
                      ((r_state == ST_IDLE) | ((r_state == ST_ODD) & i_out_ready));
  assign o_in_ready = ~r_s1_valid | w_ob_load;
  assign w_accept   = i_in_valid & o_in_ready;

  // ---- S1 stage: control ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_ob_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // ---- S1 / OB data: no reset, qualified by the control path ----
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_s1_l <= i_in_l;
      r_s1_h <= i_in_h;
    end
    if (w_ob_load) begin
      r_ob_even <= w_even;
      r_ob_odd  <= w_odd;
    end
  end

  // ---- Serializer FSM ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    o_out_even  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_s1_valid) w_state_nxt = ST_EVEN;
      end
      ST_EVEN: begin
        o_out_valid = 1'b1;
        o_out_data  = r_ob_even;
        o_out_even  = 1'b1;
        if (i_out_ready) w_state_nxt = ST_ODD;
      end
      ST_ODD: begin
        o_out_valid = 1'b1;
        o_out_data  = r_ob_odd;
        if (i_out_ready) w_state_nxt = r_s1_valid ? ST_EVEN : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef ILIFT_CNT_EN
  logic [15:0] r_pair_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pair_cnt <= 16'd0;
    end else if (w_accept) begin
      r_pair_cnt <= r_pair_cnt + 16'd1;
    end
  end

  assign o_pair_cnt = r_pair_cnt;
`endif

endmodule

// File: tb/tb_ilift_decode.sv
// Bench for ilift_decode: directed scenarios plus a randomized round trip,
// checked against an arithmetic model of the lifting rules.
module tb_ilift_decode;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_l = '0;
  logic [W-1:0] in_h = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_even;
  logic [W-1:0] out_data;
`ifdef ILIFT_CNT_EN
  logic [15:0]  pair_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_e[$];
  logic [W-1:0] got_q[$];
  logic         last_acc;
  logic         last_rdy;
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_even;

  always #5 clk = ~clk;

  ilift_decode #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_l      (in_l),
    .i_in_h      (in_h),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_even  (out_even)
`ifdef ILIFT_CNT_EN
    ,
    .o_pair_cnt  (pair_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic, written directly from the lifting equations.
  function automatic logic [W-1:0] ref_even(input logic [W-1:0] l, input logic [W-1:0] h);
    int v;
    v = (int'(l) - 2 * (int'(h) / 4)) & 255;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_odd(input logic [W-1:0] e, input logic [W-1:0] h);
    int v;
    v = (int'(h) + 2 * (int'(e) / 2)) & 255;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] fwd_h(input logic [W-1:0] e, input logic [W-1:0] o);
    int v;
    v = (int'(o) - 2 * (int'(e) / 2)) & 255;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] fwd_l(input logic [W-1:0] e, input logic [W-1:0] h);
    int v;
    v = (int'(e) + 2 * (int'(h) / 4)) & 255;
    return v[W-1:0];
  endfunction

  // One clock: observe handshakes at the negedge, return just after the posedge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    last_rdy = in_ready;
    last_acc = in_valid && in_ready;
    if (hold_prev) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, hold_data);
      check("hold_even", out_even, hold_even);
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    hold_even = out_even;
    if (last_acc) begin
      n_acc++;
      e = ref_even(in_l, in_h);
      exp_q.push_back(e);
      exp_e.push_back(1'b1);
      exp_q.push_back(ref_odd(e, in_h));
      exp_e.push_back(1'b0);
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
        check("out_even", out_even, exp_e.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  logic [W-1:0] bl[4] = '{8'h32, 8'h60, 8'hFE, 8'h80};
  logic [W-1:0] bh[4] = '{8'h22, 8'h20, 8'h02, 8'hFD};
  logic [W-1:0] bb_exp[8] = '{8'h22, 8'h44, 8'h50, 8'h70, 8'hFE, 8'h00, 8'h02, 8'hFF};
  logic         rdy_log[16];
  logic [W-1:0] orig[$];
  logic [W-1:0] rt_l[$];
  logic [W-1:0] rt_h[$];

  initial begin
    int idx;
    int cyc;
    logic [W-1:0] e;
    logic [W-1:0] o;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_even", out_even, 1'b0);
`ifdef ILIFT_CNT_EN
    check("rst_pair_cnt", pair_cnt, 16'h0000);
`endif
    rst_n = 1'b1;
    tick();

    // Basic pair and latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_l = 8'h32; in_h = 8'h22;
    tick();
    check("basic_acc", last_acc, 1'b1);
    in_valid = 1'b0;
    check("lat_t1_valid", out_valid, 1'b0);
    tick();
    check("lat_t2_valid", out_valid, 1'b1);
    check("basic_even_data", out_data, 8'h22);
    check("basic_even_flag", out_even, 1'b1);
    tick();
    check("basic_odd_data", out_data, 8'h44);
    check("basic_odd_flag", out_even, 1'b0);
    tick();
    check("basic_idle", out_valid, 1'b0);
    drain("basic_drain");

    // Back-to-back pairs, including wrap-around values
    got_q.delete();
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 16) begin
      in_valid = 1'b1; in_l = bl[idx]; in_h = bh[idx];
      tick();
      rdy_log[cyc] = last_rdy;
      if (last_acc) idx++;
      cyc++;
    end
    check("bb_accepted", idx, 4);
    drain("bb_drain");
    check("bb_ready_c2", rdy_log[2], 1'b0);
    check("bb_ready_c3", rdy_log[3], 1'b1);
    check("bb_ready_c4", rdy_log[4], 1'b0);
    check("bb_ready_c5", rdy_log[5], 1'b1);
    check("bb_count", got_q.size(), 8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) check("bb_stream", got_q[k], bb_exp[k]);

    // Backpressure: only OB + S1 are absorbed
    got_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_l = bl[idx]; in_h = bh[idx];
      tick();
      if (last_acc && idx < 2) idx++;
      else if (last_acc) idx = 9;
      if (out_valid) check("bp_hold_data", out_data, 8'h22);
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 1'b0);
    drain("bp_drain");
    check("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check("bp_stream", got_q[k], bb_exp[k]);

    // Reset while the odd sample is pending
    out_ready = 1'b1;
    in_valid = 1'b1; in_l = 8'h32; in_h = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_in_odd", out_even, 1'b0);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    exp_q.delete(); exp_e.delete(); got_q.delete();
    hold_prev = 1'b0;
    n_acc = 0;
    rst_n = 1'b1;
    in_valid = 1'b1; in_l = 8'h32; in_h = 8'h22;
    tick();
    drain("mid_drain");
    check("mid_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("mid_even", got_q[0], 8'h22);
      check("mid_odd", got_q[1], 8'h44);
    end

    // Randomized round trip through the forward transform
    got_q.delete();
    for (int i = 0; i < 4096; i++) begin
      e = 8'(i);
      o = 8'($urandom_range(0, 255));
      orig.push_back(e);
      orig.push_back(o);
      rt_h.push_back(fwd_h(e, o));
      rt_l.push_back(fwd_l(e, fwd_h(e, o)));
    end
    idx = 0; cyc = 0;
    while (idx < 4096 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_l = rt_l[idx]; in_h = rt_h[idx];
      tick();
      if (last_acc) idx++;
      cyc++;
    end
    check("rt_accepted", idx, 4096);
    drain("rt_drain");
    check("rt_count", got_q.size(), orig.size());
    for (int k = 0; k < orig.size() && k < got_q.size(); k++) begin
      if (got_q[k] !== orig[k]) check("rt_roundtrip", got_q[k], orig[k]);
    end
    check("rt_roundtrip_all", got_q == orig, 1'b1);
`ifdef ILIFT_CNT_EN
    check("pair_cnt", pair_cnt, n_acc & 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
